dutmem_arb2: RTL and testbench
==============================

// Module: dutmem_arb2
// PURPOSE
//  Two-requester round-robin arbiter and init sequencer for the single-port dutmem RAM.
//  - The RAM takes ce/we/addr/din and has 1-cycle registered read data.
//  - After reset, the block sweeps every address and writes zero, then serves ports A and B.
//  - Each port has a valid/ready request channel and a fixed-latency read-response channel.
//  - Sits between the DUT-side requesters and the memory instance.
// PARAMETERS
//  DWIDTH   32                 data width
//  AWIDTH   10                 address width
//  DEPTH    (1<<AWIDTH)        words swept by init
//  INIT_EN  1                  1: zero-fill after reset; 0: go straight to RUN
// PORTS
//  clk        in   1        clock, all state updates on posedge
//  rst        in   1        synchronous reset, active-high
//  a_valid    in   1        port A request valid
//  a_ready    out  1        port A request accepted this cycle
//  a_we       in   1        port A: 1 = write, 0 = read
//  a_addr     in   AWIDTH   port A address
//  a_din      in   DWIDTH   port A write data
//  a_rvalid   out  1        port A read data valid
//  a_rdata    out  DWIDTH   port A read data
//  b_*        -    -        port B: identical set (b_valid ... b_rdata)
//  mem_ce     out  1        RAM chip enable
//  mem_we     out  1        RAM write enable
//  mem_addr   out  AWIDTH   RAM address
//  mem_din    out  DWIDTH   RAM write data
//  mem_dout   in   DWIDTH   RAM registered read data
//  init_done  out  1        high once the zero-fill has completed
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state <= INIT (or RUN if INIT_EN=0); init_cnt <= 0; last_grant <= B, so A wins the first tie.
//   - a_rvalid and b_rvalid <= 0; init_done <= 0 (1 if INIT_EN=0).
//   - Any in-flight read response is dropped.
//  FSM states: INIT, RUN. No other states. An illegal encoding goes to INIT.
//   - INIT:
//     - Drives mem_ce=1, mem_we=1, mem_addr=init_cnt, mem_din=0.
//     - init_cnt increments every cycle.
//     - At init_cnt==DEPTH-1: go to RUN and set init_done<=1 on the same edge.
//     - a_ready and b_ready are held at 0. Sweep length is exactly DEPTH cycles.
//   - RUN:
//     - One grant per cycle, combinational from the valids.
//     - Only A valid -> grant A. Only B valid -> grant B.
//     - Both valid -> grant the port not in last_grant.
//     - x_ready = grant_x. Handshake completes when x_valid & x_ready.
//     - last_grant updates only on a completed handshake.
//  Memory drive in RUN:
//   - Granted port: mem_ce=1, mem_we=x_we, mem_addr=x_addr, mem_din=x_din.
//   - No grant: mem_ce=0; mem_we, mem_addr and mem_din are 0.
//  Read latency:
//   - A read accepted in cycle N gives x_rvalid=1 in cycle N+1, for exactly 1 cycle.
//   - x_rdata = mem_dout, passed through combinationally.
//   - x_rdata is only meaningful while x_rvalid=1.
//   - Writes produce no response.
//   - Back-to-back reads give one rvalid per cycle, no bubble.
//  Ordering and hazards:
//   - Requests are serialised on the single RAM port.
//   - A write in cycle N followed by a read of the same address in N+1 (either port) returns the new data.
//   - A requester must hold valid and payload stable until ready. The arbiter does not check this.
//   - Requests presented during INIT wait, are not lost, and are accepted from the first RUN cycle.
//  Reset mid-operation:
//   - Aborts RUN or INIT immediately and restarts INIT from address 0.
//   - A read accepted in the reset cycle gives no rvalid.
// TESTING
//  1. Reset, INIT_EN=1:
//     - init_done rises exactly DEPTH cycles after reset deassert.
//     - Then read addr 0x3FF -> a_rvalid one cycle later with a_rdata=0.
//  2. A writes 0x12345678 @0x010, then B reads @0x010 the next cycle:
//     - b_rvalid=1 one cycle after B's accept, b_rdata=0x12345678.
//  3. A and B both hold valid for 6 cycles:
//     - Grants alternate A,B,A,B,A,B.
//     - Each port gets 3 accepts and never 2 in a row.
//  4. Only B valid for 4 cycles, reads @1..4 previously written 0x11..0x44:
//     - b_ready=1 every cycle.
//     - b_rvalid on 4 consecutive cycles with b_rdata 0x11,0x22,0x33,0x44.
//  5. Assert rst for 1 cycle mid-stream while a read is outstanding:
//     - No rvalid follows; init_done=0; INIT restarts at mem_addr=0.
//  6. a_valid held through INIT:
//     - a_ready=0 until init_done.
//     - The request is accepted in the first RUN cycle and mem_ce pulses once.

Source files
------------

// File: rtl/dutmem_arb2.sv
// Round-robin arbiter and zero-fill init sequencer for the single-port dutmem RAM.
// Ports A and B share the RAM. A read accepted in cycle N returns data in cycle N+1.
module dutmem_arb2 #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned AWIDTH  = 10,
  parameter int unsigned DEPTH   = (1 << AWIDTH),
  parameter bit          INIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [DWIDTH-1:0] a_din,
  output logic              a_rvalid,
  output logic [DWIDTH-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [DWIDTH-1:0] b_din,
  output logic              b_rvalid,
  output logic [DWIDTH-1:0] b_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout,
  output logic              init_done
);

  localparam logic [1:0] S_INIT = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [AWIDTH-1:0] init_cnt;
  logic              last_grant;  // 0: A won last, 1: B won last
  logic              grant_a;
  logic              grant_b;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT_EN ? S_INIT : S_RUN;
    else     state <= state_nx;
  end

  // Next state, grant selection and RAM drive
  always_comb begin
    state_nx = state;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    mem_ce   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    case (state)
      S_INIT: begin
        mem_ce   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = init_cnt;
        if (init_cnt == LAST_ADDR) state_nx = S_RUN;
      end
      S_RUN: begin
        if (a_valid && (!b_valid || last_grant)) grant_a = 1'b1;
        else if (b_valid)                         grant_b = 1'b1;
        if (grant_a) begin
          mem_ce   = 1'b1;
          mem_we   = a_we;
          mem_addr = a_addr;
          mem_din  = a_din;
        end else if (grant_b) begin
          mem_ce   = 1'b1;
          mem_we   = b_we;
          mem_addr = b_addr;
          mem_din  = b_din;
        end
      end
      default: state_nx = S_INIT;
    endcase
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign a_rdata = mem_dout;
  assign b_rdata = mem_dout;

  // Sweep counter, fairness pointer and read-response tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt   <= '0;
      last_grant <= 1'b1;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      init_done  <= !INIT_EN;
    end else begin
      if (state == S_INIT) begin
        init_cnt <= init_cnt + AWIDTH'(1);
        if (init_cnt == LAST_ADDR) init_done <= 1'b1;
      end
      if (grant_a)      last_grant <= 1'b0;
      else if (grant_b) last_grant <= 1'b1;
      a_rvalid <= grant_a & ~a_we;
      b_rvalid <= grant_b & ~b_we;
    end
  end

endmodule

// File: tb/tb_dutmem_arb2.sv
// Bench for dutmem_arb2: RAM model, arbitration reference model and response scoreboard.
module tb_dutmem_arb2;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_valid = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_din = '0;
  logic          b_valid = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_din = '0;
  logic          a_ready, a_rvalid, b_ready, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_ce, mem_we, init_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;

  dutmem_arb2 dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .init_done(init_done)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM with registered read, preloaded with garbage
  logic [DW-1:0] ram [DEPTH];
  initial begin
    foreach (ram[i]) ram[i] = $urandom;
    forever begin
      @(posedge clk);
      if (mem_ce) begin
        if (mem_we) ram[mem_addr] = mem_din;
        else        mem_dout <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { int due; logic [DW-1:0] data; } rsp_t;
  rsp_t qa[$];
  rsp_t qb[$];

  // Reference model: contents the RAM should hold, init countdown, fairness
  logic [DW-1:0] ref_mem [DEPTH];
  int            init_left = DEPTH;
  bit            lg_b = 1'b1;

  task automatic model_cycle();
    bit ga, gb;
    logic [43:0] exp_drv;
    if (rst) begin
      qa.delete();
      qb.delete();
      lg_b      = 1'b1;
      init_left = DEPTH;
      foreach (ref_mem[i]) ref_mem[i] = '0;
      return;
    end
    chk("init_done", 64'(init_done), 64'(init_left == 0));
    if (init_left > 0) begin
      chk("init_drive", {a_ready, b_ready, mem_ce, mem_we, mem_din == '0, mem_addr},
          {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, AW'(DEPTH - init_left)});
      init_left--;
    end else begin
      if (a_valid && b_valid) begin
        ga = lg_b;
        gb = !lg_b;
      end else begin
        ga = a_valid;
        gb = b_valid;
      end
      chk("ready", {a_ready, b_ready}, {ga, gb});
      exp_drv = ga ? {1'b1, a_we, a_addr, a_din} : gb ? {1'b1, b_we, b_addr, b_din} : 44'd0;
      chk("mem_drive", {mem_ce, mem_we, mem_addr, mem_din}, exp_drv);
      if (ga) begin
        lg_b = 1'b0;
        if (a_we) ref_mem[a_addr] = a_din;
        else      qa.push_back('{cyc + 1, ref_mem[a_addr]});
      end else if (gb) begin
        lg_b = 1'b1;
        if (b_we) ref_mem[b_addr] = b_din;
        else      qb.push_back('{cyc + 1, ref_mem[b_addr]});
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    model_cycle();
  end

  // Response monitor: pops whenever a port presents rvalid
  task automatic mon(input bit pb, input logic rv, input logic [DW-1:0] rd);
    rsp_t e;
    int   n;
    n = pb ? qb.size() : qa.size();
    if (n > 0) e = pb ? qb[0] : qa[0];
    if (rv) begin
      if (n == 0) begin
        total++;
        $display("FAIL rvalid_%s: got unexpected rvalid with rdata 0x%0h, required none (cycle %0d)",
                 pb ? "b" : "a", rd, cyc);
      end else begin
        if (pb) void'(qb.pop_front()); else void'(qa.pop_front());
        chk(pb ? "b_rvalid_cycle" : "a_rvalid_cycle", 64'(cyc), 64'(e.due));
        chk(pb ? "b_rdata" : "a_rdata", 64'(rd), 64'(e.data));
      end
    end else if (n > 0 && e.due <= cyc) begin
      if (pb) void'(qb.pop_front()); else void'(qa.pop_front());
      total++;
      $display("FAIL rvalid_%s: got no rvalid, required one with rdata 0x%0h (cycle %0d)",
               pb ? "b" : "a", e.data, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon(1'b0, a_rvalid, a_rdata);
    mon(1'b1, b_rvalid, b_rdata);
  end

  // Stimulus
  bit acc_a, acc_b;

  task automatic cycle();
    @(negedge clk);
    acc_a = a_valid & a_ready;
    acc_b = b_valid & b_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    int n = 0;
    while (a_valid || b_valid) begin
      cycle();
      if (acc_a) a_valid = 1'b0;
      if (acc_b) b_valid = 1'b0;
      n++;
      if (n > 1200) begin
        total++;
        $display("FAIL settle: got pending request after %0d cycles, required acceptance", n);
        a_valid = 1'b0;
        b_valid = 1'b0;
      end
    end
  endtask

  task automatic rnd_cycles(input int n, input int prob);
    for (int i = 0; i < n; i++) begin
      if (!a_valid || acc_a) begin
        a_valid = ($urandom_range(99) < prob);
        a_we    = 1'($urandom_range(1));
        a_addr  = AW'($urandom_range(15));
        a_din   = $urandom;
      end
      if (!b_valid || acc_b) begin
        b_valid = ($urandom_range(99) < prob);
        b_we    = 1'($urandom_range(1));
        b_addr  = AW'($urandom_range(15));
        b_din   = $urandom;
      end
      cycle();
    end
  endtask

  initial begin
    // Read of the top address held through the whole zero-fill
    a_valid = 1'b1;
    a_we    = 1'b0;
    a_addr  = 10'h3FF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    settle();

    // Write on A, read-back on B the next cycle
    a_valid = 1'b1; a_we = 1'b1; a_addr = 10'h010; a_din = 32'h12345678;
    cycle();
    a_valid = 1'b0;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 10'h010;
    cycle();
    b_valid = 1'b0;

    // Fill 1..4 from A, then back-to-back reads from B
    for (int i = 1; i <= 4; i++) begin
      a_valid = 1'b1; a_we = 1'b1; a_addr = AW'(i); a_din = 32'(i * 32'h11);
      cycle();
    end
    a_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      b_valid = 1'b1; b_we = 1'b0; b_addr = AW'(i);
      cycle();
    end
    b_valid = 1'b0;

    // Contention, then random traffic
    acc_a = 1'b0;
    acc_b = 1'b0;
    rnd_cycles(6, 100);
    rnd_cycles(300, 60);
    settle();

    // Reset while a read is being accepted
    a_valid = 1'b1; a_we = 1'b0; a_addr = AW'(2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    a_valid = 1'b0;
    acc_a = 1'b0;
    acc_b = 1'b0;
    rnd_cycles(1100, 50);
    settle();
    repeat (3) cycle();

    chk("queues_drained", 64'(qa.size() + qb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
